// File: rtl/branch_pc_seq.sv
// Program counter owner and sequencer for the conditional-branch instructions
// (brzr/brnz/brpl/brmi). A branch walks IDLE -> TEST -> SAMPLE -> ADD -> COMMIT:
// Ra is driven onto the bus while the CON latch is strobed, the latched CON
// value is sampled, the branch target is formed, and the PC is updated only if
// the branch is taken. Plain increment/load requests are serviced in IDLE.
module branch_pc_seq #(
    parameter int                 ADDR_W   = 32,
    parameter int                 OFF_W    = 19,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [31:0]       ir,
    input  logic              pc_inc,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_din,
    input  logic              con_val,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        ra_sel,
    output logic              ra_out,
    output logic              con_in,
    output logic [1:0]        c2_field,
    output logic              busy,
    output logic              done,
    output logic              taken
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TEST   = 3'd1,
        S_SAMPLE = 3'd2,
        S_ADD    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_target;
    logic [OFF_W-1:0]    r_c_q;
    logic                r_con_q;
    logic [3:0]          r_ra_sel;
    logic                r_ra_out;
    logic                r_con_in;
    logic [1:0]          r_c2_field;
    logic                r_done;
    logic                r_taken;

    logic [ADDR_W-1:0]   w_off_sext;
    logic                w_unused_ir;

    // Branch offset sign-extended to the PC width; the add wraps modulo 2^ADDR_W.
    assign w_off_sext  = {{(ADDR_W-OFF_W){r_c_q[OFF_W-1]}}, r_c_q};
    // Opcode and Rb-style fields of the instruction are not needed here.
    assign w_unused_ir = ^{ir[31:27], ir[22:21]};

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: the branch sequence is a fixed walk once started.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_state_next = S_TEST;
            S_TEST:   w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = S_ADD;
            S_ADD:    w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_pc       <= RESET_PC;
            r_target   <= '0;
            r_c_q      <= '0;
            r_con_q    <= 1'b0;
            r_ra_sel   <= 4'd0;
            r_ra_out   <= 1'b0;
            r_con_in   <= 1'b0;
            r_c2_field <= 2'd0;
            r_done     <= 1'b0;
            r_taken    <= 1'b0;
        end else begin
            r_ra_out <= 1'b0;
            r_con_in <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Latch all instruction fields so later ir changes cannot disturb the branch.
                        r_ra_sel   <= ir[26:23];
                        r_c2_field <= ir[20:19];
                        r_c_q      <= ir[OFF_W-1:0];
                        r_ra_out   <= 1'b1;
                        r_con_in   <= 1'b1;
                    end else if (pc_load) begin
                        r_pc <= pc_din;
                    end else if (pc_inc) begin
                        r_pc <= r_pc + ADDR_W'(1);
                    end
                end
                S_TEST: begin
                    // conff latches CON at the end of TEST; nothing to do here.
                end
                S_SAMPLE: begin
                    r_con_q <= con_val;
                end
                S_ADD: begin
                    // done and taken are raised together so taken is valid with the pulse.
                    r_target <= r_pc + w_off_sext;
                    r_done   <= 1'b1;
                    r_taken  <= r_con_q;
                end
                S_COMMIT: begin
                    if (r_con_q) begin
                        r_pc <= r_target;
                    end
                    r_c2_field <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign ra_sel   = r_ra_sel;
    assign ra_out   = r_ra_out;
    assign con_in   = r_con_in;
    assign c2_field = r_c2_field;
    assign done     = r_done;
    assign taken    = r_taken;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_branch_pc_seq.sv
// Scoreboard bench for branch_pc_seq: the driver issues branches and PC
// requests and queues the expected branch outcome; a monitor pops on each
// CON strobe / done pulse and compares. A small conff model answers con_in
// from a bench-held register file.
module tb_branch_pc_seq;

    logic        clk = 1'b0;
    logic        clr_n, start, pc_inc, pc_load;
    logic [31:0] ir, pc_din;
    logic        con_val;
    logic [31:0] pc;
    logic [3:0]  ra_sel;
    logic        ra_out, con_in, busy, done, taken;
    logic [1:0]  c2_field;

    always #5 clk = ~clk;

    branch_pc_seq #(.ADDR_W(32), .OFF_W(19), .RESET_PC(32'h0)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .ir(ir),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_din(pc_din), .con_val(con_val),
        .pc(pc), .ra_sel(ra_sel), .ra_out(ra_out), .con_in(con_in),
        .c2_field(c2_field), .busy(busy), .done(done), .taken(taken)
    );

    typedef struct {
        logic [3:0]  ra;
        logic [1:0]  c2;
        logic        tk;
        logic [31:0] npc;
        int          s;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] regs [16];
    logic [31:0] model_pc;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    function automatic logic cond(input logic [31:0] v, input logic [1:0] c2);
        case (c2)
            2'd0:    return (v == 32'd0);
            2'd1:    return (v != 32'd0);
            2'd2:    return (v[31] == 1'b0);
            default: return (v[31] == 1'b1);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // conff model: CON latched from the selected register when strobed.
    always @(posedge clk) begin
        if (!clr_n) con_val <= 1'b0;
        else if (con_in) con_val <= cond(regs[ra_sel], c2_field);
    end

    // Monitor: checks strobe fields, done/taken/latency and the PC after done.
    logic        prev_con, prev_done, pend;
    logic [31:0] pend_pc;
    initial begin prev_con = 0; prev_done = 0; pend = 0; pend_pc = 0; end
    always @(negedge clk) begin
        exp_t it;
        if (!clr_n) begin
            pend = 0; prev_con = 0; prev_done = 0;
        end else begin
            if (pend) begin
                chk("pc_after_branch", pc, pend_pc);
                pend = 0;
            end
            if (con_in) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL con_in_unexpected: got strobe expected none");
                end else begin
                    chk("ra_sel", {28'd0, ra_sel}, {28'd0, sb[0].ra});
                    chk("c2_field", {30'd0, c2_field}, {30'd0, sb[0].c2});
                    chk("ra_out", {31'd0, ra_out}, 32'd1);
                end
                if (prev_con) chk("con_in_width", 32'd2, 32'd1);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL done_unexpected: got done expected none");
                end else begin
                    it = sb.pop_front();
                    chk("taken", {31'd0, taken}, {31'd0, it.tk});
                    chk("latency", cyc, it.s + 3);
                    pend = 1;
                    pend_pc = it.npc;
                end
                if (prev_done) chk("done_width", 32'd2, 32'd1);
            end
            prev_con  = con_in;
            prev_done = done;
        end
    end

    task automatic do_load(input logic [31:0] v);
        pc_din = v; pc_load = 1;
        @(posedge clk); #1;
        pc_load = 0;
        model_pc = v;
        chk("pc_load", pc, v);
    endtask

    task automatic do_inc();
        pc_inc = 1;
        @(posedge clk); #1;
        pc_inc = 0;
        model_pc = model_pc + 32'd1;
        chk("pc_inc", pc, model_pc);
    endtask

    task automatic do_branch(input logic [3:0] ra, input logic [1:0] c2, input logic [18:0] c,
                             input bit with_req, input bit noise);
        exp_t it;
        int   off;
        ir = $urandom;
        ir[26:23] = ra; ir[20:19] = c2; ir[18:0] = c;
        start = 1;
        if (with_req) begin pc_inc = 1; pc_load = 1; pc_din = $urandom; end
        @(posedge clk); #1;
        off = c[18] ? (int'(c) - (1 << 19)) : int'(c);
        it.ra = ra; it.c2 = c2;
        it.tk = cond(regs[ra], c2);
        it.npc = it.tk ? (model_pc + 32'(off)) : model_pc;
        it.s = cyc;
        sb.push_back(it);
        model_pc = it.npc;
        start = 0; pc_inc = 0; pc_load = 0;
        ir = $urandom;
        if (noise) begin
            start = 1; pc_inc = 1; pc_load = 1; pc_din = $urandom;
            @(posedge clk); #1;
            @(posedge clk); #1;
            start = 0; pc_inc = 0; pc_load = 0;
        end
        for (int k = 0; k < 12; k++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("idle_after_branch", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clr_n = 0; start = 1; pc_inc = 1; pc_load = 0; ir = 32'h0; pc_din = 32'h0;
        model_pc = 32'h0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       regs[i] = 32'h0;
                1:       regs[i] = $urandom & 32'h7FFF_FFFF;
                default: regs[i] = $urandom | 32'h8000_0000;
            endcase
        end

        // Reset held with requests asserted.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_pc", pc, 32'h0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_con_in", {31'd0, con_in}, 32'd0);
        end
        start = 0; pc_inc = 0; clr_n = 1;
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_c2", {30'd0, c2_field}, 32'd0);

        // brzr taken.
        do_load(32'h10);
        regs[5] = 32'h0;
        do_branch(4'd5, 2'b00, 19'h00014, 0, 0);
        // brnz not taken, then taken with negative offset.
        do_load(32'h100);
        regs[3] = 32'h0;
        do_branch(4'd3, 2'b01, 19'h7FFFC, 0, 0);
        regs[4] = 32'h7;
        do_branch(4'd4, 2'b01, 19'h7FFFC, 0, 0);
        // Wrap-around.
        do_load(32'hFFFF_FFFF);
        do_inc();
        do_load(32'h2);
        do_branch(4'd5, 2'b00, 19'h7FFFD, 0, 0);
        // Priority: start wins over same-cycle load/inc; requests while busy ignored.
        do_branch(4'd5, 2'b00, 19'h00008, 1, 0);
        do_branch(4'd5, 2'b00, 19'h00004, 0, 1);
        do_load(32'hABCD);
        // Random mix, branches back-to-back.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 1) do_load($urandom);
            else if (r < 2) do_inc();
            else do_branch(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                           19'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end

        // Reset during ADD aborts a would-be-taken branch.
        @(posedge clk); #1;
        do_load(32'h40);
        regs[2] = 32'h0;
        ir = 32'h0; ir[26:23] = 4'd2; ir[18:0] = 19'h10;
        start = 1;
        @(posedge clk); #1;
        begin
            exp_t it;
            it.ra = 4'd2; it.c2 = 2'b00; it.tk = 1; it.npc = 32'h50; it.s = cyc;
            sb.push_back(it);
        end
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr_n = 0;
        @(posedge clk); #1;
        clr_n = 1;
        void'(sb.pop_back());
        model_pc = 32'h0;
        chk("abort_pc", pc, 32'h0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("abort_pc_hold", pc, 32'h0);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
